fir_serial_param: RTL and testbench

//  Parametrised single-MAC serial FIR filter; next generation of the fixed 8-tap fir block.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_mac.sv | 56 +++++
 rtl/fir_serial_param.sv | 146 ++++++++++++++
 tb/tb_fir_serial_param.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the serial FIR filter.
//   fir_state_e : controller states (IDLE -> MAC -> DONE -> IDLE)
//   DEF_*       : default widths and tap count used by the top-level parameters
//   clog2       : ceiling log2, used for pointer and output-width sizing
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fir_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_COEF_W = 8;
  localparam int DEF_TAPS   = 8;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Registered multiply-accumulate unit for the serial FIR.
// Ports:
//   clock  : rising-edge clock
//   reset  : asynchronous, active-low reset (acc cleared)
//   init_i : synchronous clear of the accumulator (wins over en_i)
//   en_i   : add a_i*b_i to the accumulator this cycle
//   a_i    : coefficient operand (A_W bits)
//   b_i    : sample operand (B_W bits)
//   acc_o  : accumulator value (OUT_W bits)
// With SIGNED != 0 the operands and the product are treated as two's complement.
module fir_mac #(
  parameter int A_W    = 8,
  parameter int B_W    = 8,
  parameter int OUT_W  = 19,
  parameter int SIGNED = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init_i,
  input  logic             en_i,
  input  logic [A_W-1:0]   a_i,
  input  logic [B_W-1:0]   b_i,
  output logic [OUT_W-1:0] acc_o
);

  localparam int PW = A_W + B_W;

  logic [PW-1:0]    aExt;
  logic [PW-1:0]    bExt;
  logic [PW-1:0]    prod;
  logic [OUT_W-1:0] prodExt;
  logic [OUT_W-1:0] acc_q;

  // Extending both operands to the full product width before multiplying
  // makes the low PW bits of the unsigned product equal to the two's
  // complement product, so one multiplier serves both modes.
  always_comb begin
    aExt    = {{B_W{(SIGNED != 0) && a_i[A_W-1]}}, a_i};
    bExt    = {{A_W{(SIGNED != 0) && b_i[B_W-1]}}, b_i};
    prod    = aExt * bExt;
    prodExt = {{(OUT_W-PW){(SIGNED != 0) && prod[PW-1]}}, prod};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else if (init_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + prodExt;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_serial_param.sv
// Parametrised single-MAC serial FIR filter with a writable coefficient bank.
// Ports:
//   clock     : rising-edge clock
//   reset     : asynchronous, active-low reset
//   valid_in  : sample x is valid
//   ready_in  : block can accept a sample (high only in IDLE)
//   x         : input sample (DATA_W)
//   clear     : synchronous history clear / computation abort
//   coef_we   : coefficient write strobe (honoured only while ready_in)
//   coef_addr : tap index, 0 = newest sample
//   coef_data : coefficient value (COEF_W)
//   y         : filter output, held until the next result (OUT_W)
//   valid_out : one-cycle pulse when y is updated
// One accepted sample produces one result TAPS+1 edges later; the next sample
// can be taken TAPS+2 cycles after the previous one.
module fir_serial_param
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int SIGNED = 0,
  parameter int OUT_W  = DATA_W + COEF_W + clog2(TAPS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [DATA_W-1:0]      x,
  input  logic                   clear,
  input  logic                   coef_we,
  input  logic [clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]      coef_data,
  output logic [OUT_W-1:0]       y,
  output logic                   valid_out
);

  localparam int            AW   = clog2(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

  fir_state_e        state_q, state_d;
  logic [AW-1:0]     tapIdx_q;
  logic [AW-1:0]     headPtr_q;
  logic [AW-1:0]     rdPtr_q;
  logic [DATA_W-1:0] hist_q [TAPS];
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [OUT_W-1:0]  y_q;
  logic              validOut_q;

  logic              accept;
  logic              coefWrite;
  logic              macInit;
  logic              macEn;
  logic              lastTap;
  logic [AW-1:0]     headNext;
  logic [AW-1:0]     rdPrev;
  logic [OUT_W-1:0]  acc;

  // Pointers wrap by explicit compare so non-power-of-two TAPS works.
  assign lastTap  = (tapIdx_q == LAST);
  assign headNext = (headPtr_q == LAST) ? '0 : headPtr_q + AW'(1);
  assign rdPrev   = (rdPtr_q == '0) ? LAST : rdPtr_q - AW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // clear overrides every transition.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (valid_in) state_d = MAC;
        MAC:     if (lastTap) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // A coefficient write shares the IDLE window with sample accept, so a
  // write landing on the accept edge is already visible to the first MAC.
  always_comb begin
    ready_in  = (state_q == IDLE);
    accept    = ready_in && valid_in && !clear;
    coefWrite = ready_in && coef_we && !clear && (coef_addr <= LAST);
    macInit   = accept || clear;
    macEn     = (state_q == MAC) && !clear;
  end

  // rdPtr walks backwards from the newest sample while tapIdx walks the
  // coefficients forwards; tapIdx stops at LAST to stay inside the bank.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tapIdx_q   <= '0;
      headPtr_q  <= '0;
      rdPtr_q    <= '0;
      y_q        <= '0;
      validOut_q <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      validOut_q <= (state_q == DONE) && !clear;
      if ((state_q == DONE) && !clear) y_q <= acc;
      if (coefWrite) coef_q[coef_addr] <= coef_data;
      if (clear) begin
        tapIdx_q  <= '0;
        headPtr_q <= '0;
        rdPtr_q   <= '0;
        for (int i = 0; i < TAPS; i++) hist_q[i] <= '0;
      end else if (accept) begin
        hist_q[headNext] <= x;
        headPtr_q        <= headNext;
        rdPtr_q          <= headNext;
        tapIdx_q         <= '0;
      end else if (macEn) begin
        rdPtr_q <= rdPrev;
        if (!lastTap) tapIdx_q <= tapIdx_q + AW'(1);
      end
    end
  end

  fir_mac #(
    .A_W    (COEF_W),
    .B_W    (DATA_W),
    .OUT_W  (OUT_W),
    .SIGNED (SIGNED)
  ) uMac (
    .clock  (clock),
    .reset  (reset),
    .init_i (macInit),
    .en_i   (macEn),
    .a_i    (coef_q[tapIdx_q]),
    .b_i    (hist_q[rdPtr_q]),
    .acc_o  (acc)
  );

  assign y         = y_q;
  assign valid_out = validOut_q;

endmodule

// File: tb/tb_fir_serial_param.sv
// Bench for fir_serial_param: an unsigned and a signed instance share one
// stimulus stream; a direct-form model predicts both outputs per accepted
// sample into a scoreboard, and directed steps check the known result values.
module tb_fir_serial_param;

  localparam int TAPS = 8;

  typedef struct {
    logic [18:0] yU;
    logic [18:0] yS;
    int          due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        clear = 1'b0;
  logic        coef_we = 1'b0;
  logic [7:0]  x = '0;
  logic [7:0]  coef_data = '0;
  logic [2:0]  coef_addr = '0;
  logic        readyU, readyS, validU, validS;
  logic [18:0] yU, yS;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          mCnt = 0;
  int          pulses = 0;
  exp_t        sb[$];
  logic [18:0] obsU[$];
  logic [18:0] obsS[$];

  logic [7:0]  coefM [TAPS];
  logic [7:0]  histM [TAPS];
  longint      su, ss;
  exp_t        eModel, eMon;

  always #5 clock = ~clock;

  fir_serial_param #(.SIGNED(0)) dutU (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(readyU), .x(x),
    .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(yU), .valid_out(validU)
  );

  fir_serial_param #(.SIGNED(1)) dutS (
    .clock(clock), .reset(reset), .valid_in(valid_in), .ready_in(readyS), .x(x),
    .clear(clear), .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .y(yS), .valid_out(validS)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: shift-register history, busy countdown of TAPS+1 cycles.
  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      for (int k = 0; k < TAPS; k++) begin
        coefM[k] = '0;
        histM[k] = '0;
      end
      mCnt = 0;
      sb.delete();
    end else begin
      cyc++;
      if (clear) begin
        if (mCnt > 0 && sb.size() > 0) void'(sb.pop_back());
        for (int k = 0; k < TAPS; k++) histM[k] = '0;
        mCnt = 0;
      end else begin
        if (mCnt == 0 && coef_we) coefM[coef_addr] = coef_data;
        if (mCnt == 0 && valid_in) begin
          for (int k = TAPS - 1; k > 0; k--) histM[k] = histM[k-1];
          histM[0] = x;
          su = 0;
          ss = 0;
          for (int k = 0; k < TAPS; k++) begin
            su += longint'(coefM[k]) * longint'(histM[k]);
            ss += longint'($signed(coefM[k])) * longint'($signed(histM[k]));
          end
          eModel.yU  = su[18:0];
          eModel.yS  = ss[18:0];
          eModel.due = cyc + TAPS + 1;
          sb.push_back(eModel);
          mCnt = TAPS + 1;
        end else if (mCnt > 0) begin
          mCnt--;
        end
      end
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clock);
    if (reset) begin
      checkOutput("readyU", readyU, (mCnt == 0));
      checkOutput("readyS", readyS, (mCnt == 0));
      if (validU || validS) begin
        pulses++;
        if (sb.size() == 0) begin
          checkOutput("unexpectedPulse", sb.size(), 1);
        end else begin
          eMon = sb.pop_front();
          checkOutput("validPair", {validU, validS}, 2'b11);
          checkOutput("yUnsigned", yU, eMon.yU);
          checkOutput("ySigned", yS, eMon.yS);
          checkOutput("latency", cyc, eMon.due);
          obsU.push_back(yU);
          obsS.push_back(yS);
        end
      end
    end
  end

  task automatic writeCoef(input logic [2:0] addr, input logic [7:0] data);
    @(negedge clock);
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_data = data;
    @(posedge clock);
    #1 coef_we = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] sample);
    int waited;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!readyU && waited < 200);
    if (!readyU) checkOutput("readyTimeout", readyU, 1);
    valid_in = 1'b1;
    x        = sample;
    @(posedge clock);
    #1 valid_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      #1;
      if (sb.size() == 0) break;
    end
    checkOutput("drain", sb.size(), 0);
  endtask

  task automatic clearLogs();
    obsU.delete();
    obsS.delete();
  endtask

  initial begin
    int p0;
    int accepts;
    logic [18:0] yHold;

    // Reset state
    #2 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstYU", yU, 0);
    checkOutput("rstYS", yS, 0);
    checkOutput("rstValidU", validU, 0);
    checkOutput("rstValidS", validS, 0);
    @(negedge clock);
    reset = 1'b1;
    #1 checkOutput("rstReady", readyU, 1);

    // Impulse response with coef[k] = k+1
    $display("[TB] impulse");
    for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 8'(k + 1));
    clearLogs();
    applyStimulus(8'd1);
    for (int k = 0; k < TAPS; k++) applyStimulus(8'd0);
    drain();
    checkOutput("impulseCount", obsU.size(), 9);
    for (int i = 0; i < 9; i++) begin
      checkOutput("impulseU", obsU[i], (i < 8) ? i + 1 : 0);
      checkOutput("impulseS", obsS[i], (i < 8) ? i + 1 : 0);
    end

    // Full scale: coef = 255 everywhere, x = 255 eight times
    $display("[TB] full scale");
    for (int k = 0; k < TAPS; k++) writeCoef(3'(k), 8'hFF);
    clearLogs();
    for (int k = 0; k < TAPS; k++) applyStimulus(8'hFF);
    drain();
    checkOutput("fullCount", obsU.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkOutput("fullU", obsU[i], (i + 1) * 65025);
      checkOutput("fullS", obsS[i], i + 1);
    end
    checkOutput("fullU8", obsU[7], 520200);

    // Signed corner: coef[0] = -1, others 0
    $display("[TB] signed");
    writeCoef(3'd0, 8'hFF);
    for (int k = 1; k < TAPS; k++) writeCoef(3'(k), 8'h00);
    clearLogs();
    applyStimulus(8'h80);
    applyStimulus(8'h7F);
    drain();
    checkOutput("signedNeg128", obsS[0], 128);
    checkOutput("signed127", obsS[1], 32'h7FF81);
    checkOutput("unsigned128", obsU[0], 32640);
    checkOutput("unsigned127", obsU[1], 32385);

    // Coefficient write during MAC is dropped; write in IDLE is used
    $display("[TB] coef write timing");
    clearLogs();
    applyStimulus(8'd2);
    repeat (3) @(negedge clock);
    writeCoef(3'd0, 8'd5);
    drain();
    writeCoef(3'd0, 8'd3);
    applyStimulus(8'd2);
    drain();
    checkOutput("dropWriteU", obsU[0], 510);
    checkOutput("dropWriteS", obsS[0], 32'h7FFFE);
    checkOutput("idleWriteU", obsU[1], 6);
    checkOutput("idleWriteS", obsS[1], 6);

    // valid_in held high for 30 cycles
    $display("[TB] handshake");
    clearLogs();
    p0 = pulses;
    accepts = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      valid_in = 1'b1;
      x = 8'($urandom_range(0, 255));
      if (readyU) accepts++;
    end
    @(negedge clock);
    valid_in = 1'b0;
    drain();
    checkOutput("heldAccepts", accepts, 3);
    checkOutput("heldPulses", pulses - p0, 3);

    // clear in the middle of MAC
    $display("[TB] clear");
    clearLogs();
    applyStimulus(8'd9);
    yHold = yU;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1 clear = 1'b0;
    checkOutput("clearReady", readyU, 1);
    p0 = pulses;
    repeat (12) @(negedge clock);
    checkOutput("clearNoPulse", pulses - p0, 0);
    checkOutput("clearYHold", yU, yHold);
    applyStimulus(8'd1);
    drain();
    checkOutput("clearImpulseU", obsU[0], 3);
    checkOutput("clearImpulseS", obsS[0], 3);

    // Asynchronous reset mid-MAC, off the clock edge
    $display("[TB] reset mid-MAC");
    applyStimulus(8'd5);
    repeat (3) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midRstYU", yU, 0);
    checkOutput("midRstYS", yS, 0);
    checkOutput("midRstValidU", validU, 0);
    checkOutput("midRstValidS", validS, 0);
    #4 reset = 1'b1;
    @(negedge clock);
    #1 checkOutput("midRstReady", readyU, 1);
    clearLogs();
    applyStimulus(8'd7);
    drain();
    checkOutput("coefZeroCount", obsU.size(), 1);
    checkOutput("coefZeroU", obsU[0], 0);
    checkOutput("coefZeroS", obsS[0], 0);

    checkOutput("sbEmpty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
